clkdiv_strobes: RTL and testbench

CLKDIV_STROBES -- requirements
Module: clkdiv_strobes

---
 rtl/clkdiv_pkg.sv | 8 +
 rtl/clkdiv_chan.sv | 83 ++++++++
 rtl/clkdiv_strobes.sv | 42 ++++
 tb/tb_clkdiv_strobes.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants for the clkdiv_strobes divider slice.
package clkdiv_pkg;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned NCH_MAX   = 8;
  localparam int unsigned CH_W      = 3;

  typedef logic [CH_W-1:0] ch_idx_t;
endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active/pending divisor, strobe and square wave.
// Square-wave flop exists only when CLKDIV_SQW_EN is defined.
module clkdiv_chan #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wdata,
  output logic             o_strobe,
  output logic             o_sqw,
  output logic             o_pend
);
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pdiv;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_strobe;

  logic             w_en;
  logic             w_wrap;
  logic [CNT_W-1:0] w_next_div;
  logic             w_next_on;

  assign w_en       = (r_div != '0);
  assign w_wrap     = i_run && w_en && (r_cnt == r_div - CNT_W'(1));
  // Divisor in force after this wrap; a pending zero disables the channel there.
  assign w_next_div = r_pend ? r_pdiv : r_div;
  assign w_next_on  = (w_next_div != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div    <= CNT_W'(DEF_DIV);
      r_pdiv   <= '0;
      r_pend   <= 1'b0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else if (i_sync) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_pend   <= 1'b0;
      if (i_wr)        r_div <= i_wdata;
      else if (r_pend) r_div <= r_pdiv;
    end else if (!w_en) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      if (i_wr) r_div <= i_wdata;
    end else begin
      r_strobe <= w_wrap && w_next_on;
      if (w_wrap) begin
        r_cnt  <= '0;
        r_div  <= w_next_div;
        r_pend <= 1'b0;
      end else if (i_run) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // A write landing on a wrap edge is held for the following wrap.
      if (i_wr) begin
        r_pdiv <= i_wdata;
        r_pend <= 1'b1;
      end
    end
  end

`ifdef CLKDIV_SQW_EN
  logic r_sqw;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_sync || !w_en) r_sqw <= 1'b0;
    else if (w_wrap)              r_sqw <= w_next_on ? ~r_sqw : 1'b0;
  end

  assign o_sqw = r_sqw;
`else
  assign o_sqw = 1'b0;
`endif

  assign o_strobe = r_strobe;
  assign o_pend   = r_pend;
endmodule

// File: rtl/clkdiv_strobes.sv
// Multi-channel strobe generator: config decode and sync fan-out over clkdiv_chan.
// Optional square-wave outputs enabled by macro CLKDIV_SQW_EN.
module clkdiv_strobes
  import clkdiv_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clkin,
  input  logic             greset,
  input  logic             run,
  input  logic             sync,
  input  logic             cfg_we,
  input  ch_idx_t          cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [NCH-1:0]   strobe,
  output logic [NCH-1:0]   sqw,
  output logic [NCH-1:0]   pend
);
  logic [NCH-1:0] w_wr;

  // Indices >= NCH match no channel, so such writes fall away here.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign w_wr[gi] = cfg_we && (cfg_ch == ch_idx_t'(gi));

    clkdiv_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .i_clk    (clkin),
      .i_rst    (greset),
      .i_run    (run),
      .i_sync   (sync),
      .i_wr     (w_wr[gi]),
      .i_wdata  (cfg_div),
      .o_strobe (strobe[gi]),
      .o_sqw    (sqw[gi]),
      .o_pend   (pend[gi])
    );
  end
endmodule

// File: tb/tb_clkdiv_strobes.sv
// Directed bench for clkdiv_strobes (NCH=2, DEF_DIV=4): vector table plus corner sequences.
module tb_clkdiv_strobes;
  logic        clk = 1'b0;
  logic        greset, run, sync, cfg_we;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [1:0]  strobe, sqw, pend;

  int n_checks = 0;
  int n_err    = 0;

`ifdef CLKDIV_SQW_EN
  localparam logic [1:0] SQM = 2'b11;
`else
  localparam logic [1:0] SQM = 2'b00;
`endif

  clkdiv_strobes #(
    .NCH     (2),
    .CNT_W   (16),
    .DEF_DIV (4)
  ) dut (
    .clkin   (clk),
    .greset  (greset),
    .run     (run),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .strobe  (strobe),
    .sqw     (sqw),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, run, sync, we;
    logic [2:0]  ch;
    logic [15:0] div;
    logic [1:0]  stb, sqw, pnd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rn, input logic sy, input logic we,
                              input logic [2:0] ch, input logic [15:0] dv,
                              input logic [1:0] st, input logic [1:0] sq, input logic [1:0] pn);
    vec_t v;
    v.rst = r; v.run = rn; v.sync = sy; v.we = we; v.ch = ch; v.div = dv;
    v.stb = st; v.sqw = sq; v.pnd = pn;
    return v;
  endfunction

  task automatic tick(input logic r, input logic rn, input logic sy, input logic we,
                      input logic [2:0] ch, input logic [15:0] dv);
    greset = r; run = rn; sync = sy; cfg_we = we; cfg_ch = ch; cfg_div = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  initial begin
    greset = 1'b1; run = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

    // rst run sync we ch div | strobe sqw pend  (bit1 = ch1, bit0 = ch0)
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(1, 1, 1, 1, 0, 9, 2'b00, 2'b00, 2'b00));  // reset beats sync+cfg
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));  // c1
    tbl.push_back(mk(0, 1, 0, 1, 1, 3, 2'b00, 2'b00, 2'b10));  // c2: ch1 div=3 pending
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10));  // c3
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00));  // c4: both wrap, ch1 applies 3
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00));  // c7
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));  // c8
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00));  // c10
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b01, 2'b11, 2'b00));  // c12
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00));  // c13
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b11, 2'b10, 2'b00));  // c16
    tbl.push_back(mk(0, 1, 0, 1, 7, 9, 2'b00, 2'b10, 2'b00));  // c17: ch7 ignored
    tbl.push_back(mk(0, 1, 0, 1, 7, 1, 2'b00, 2'b10, 2'b00));  // c18: ch7 ignored
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00));  // c19
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00));  // c20

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].run, tbl[i].sync, tbl[i].we, tbl[i].ch, tbl[i].div);
      chk($sformatf("row%0d strobe", i), strobe, tbl[i].stb);
      chk($sformatf("row%0d sqw", i), sqw, tbl[i].sqw & SQM);
      chk($sformatf("row%0d pend", i), pend, tbl[i].pnd);
    end

    // ch0 disabled via sync+write 0, then re-enabled with div=5
    tick(0, 1, 1, 1, 0, 0);
    chk("dis strobe", strobe, 2'b00);
    chk("dis sqw", sqw, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick(0, 1, 0, 0, 0, 0);
      chk($sformatf("dis%0d strobe0", k), {1'b0, strobe[0]}, 2'b00);
      chk($sformatf("dis%0d sqw0", k), {1'b0, sqw[0]}, 2'b00);
    end
    tick(0, 1, 0, 1, 0, 5);
    chk("en pend", pend, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      tick(0, 1, 0, 0, 0, 0);
      chk($sformatf("en+%0d strobe0", k), {1'b0, strobe[0]}, {1'b0, k == 5});
      chk($sformatf("en+%0d pend", k), pend, 2'b00);
    end
    chk("en sqw0", {1'b0, sqw[0]}, {1'b0, SQM[0]});

    // sync with same-cycle write of ch0 div=2; ch1 stays at 3
    tick(0, 1, 1, 1, 0, 2);
    chk("sync strobe", strobe, 2'b00);
    chk("sync sqw", sqw, 2'b00);
    chk("sync pend", pend, 2'b00);
    tick(0, 1, 0, 0, 0, 0); chk("sync+1 strobe", strobe, 2'b00);
    tick(0, 1, 0, 0, 0, 0); chk("sync+2 strobe", strobe, 2'b01);
    tick(0, 1, 0, 0, 0, 0); chk("sync+3 strobe", strobe, 2'b10);
    tick(0, 1, 0, 0, 0, 0); chk("sync+4 strobe", strobe, 2'b01);

    // ch0 div=6 counted to 3, then paused 10 cycles
    tick(0, 1, 1, 1, 0, 6);
    for (int k = 1; k <= 3; k++) begin
      tick(0, 1, 0, 0, 0, 0);
      chk($sformatf("pre%0d strobe0", k), {1'b0, strobe[0]}, 2'b00);
    end
    chk("pre sqw", sqw, 2'b10 & SQM);
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 0, 0, 0, 0);
      chk($sformatf("hold%0d strobe", k), strobe, 2'b00);
      chk($sformatf("hold%0d sqw", k), sqw, 2'b10 & SQM);
    end
    tick(0, 1, 0, 0, 0, 0); chk("res+1 strobe", strobe, 2'b00);
    tick(0, 1, 0, 0, 0, 0); chk("res+2 strobe", strobe, 2'b00);
    tick(0, 1, 0, 0, 0, 0); chk("res+3 strobe", strobe, 2'b11);
    chk("res+3 sqw", sqw, 2'b01 & SQM);

    // pending write on ch1, then reset mid-count with sync+cfg asserted
    tick(0, 1, 0, 1, 1, 7);
    chk("pre-rst pend", pend, 2'b10);
    tick(0, 1, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 0, 1);
    chk("rst strobe", strobe, 2'b00);
    chk("rst sqw", sqw, 2'b00);
    chk("rst pend", pend, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      tick(0, 1, 0, 0, 0, 0);
      chk($sformatf("rel c%0d strobe", k), strobe, (k == 4) ? 2'b11 : 2'b00);
      chk($sformatf("rel c%0d pend", k), pend, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
